// File: rtl/xcore_if_bpu_ctrl_pkg.sv
// Shared constants for the IF-stage next-PC sequencer: opcodes, link registers,
// FSM encodings and the default boot address.
package xcore_if_bpu_ctrl_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] X1 = 5'd1;
  localparam logic [4:0] X5 = 5'd5;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } if_state_e;

  // ra (x1) and t0 (x5) are the two link registers of the calling convention.
  function automatic logic is_link(input logic [4:0] r);
    return (r == X1) || (r == X5);
  endfunction

endpackage

// File: rtl/Xcore_if_mdec.sv
// IF predecoder: classifies jal/jalr/branch and extracts register fields and
// sign-extended jump/branch offsets.
module Xcore_if_mdec
  import xcore_if_bpu_ctrl_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0] i_instr,
  output logic           o_is_jal,
  output logic           o_is_jalr,
  output logic           o_is_b,
  output logic [4:0]     o_rd,
  output logic [4:0]     o_rs1,
  output logic [LEN-1:0] o_jal_ofs,
  output logic [LEN-1:0] o_b_ofs
);

  logic [6:0]  opc;
  logic [20:0] j_imm;
  logic [12:0] b_imm;

  assign opc   = i_instr[6:0];
  assign j_imm = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign b_imm = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};

  assign o_is_jal  = (opc == OPC_JAL);
  assign o_is_jalr = (opc == OPC_JALR);
  assign o_is_b    = (opc == OPC_BRANCH);
  assign o_rd      = i_instr[11:7];
  assign o_rs1     = i_instr[19:15];
  assign o_jal_ofs = {{(LEN-21){j_imm[20]}}, j_imm};
  assign o_b_ofs   = {{(LEN-13){b_imm[12]}}, b_imm};

endmodule

// File: rtl/xcore_if_ras.sv
// Circular return-address stack: push, pop, or both at once (replace top).
// A push into a full stack overwrites the oldest entry.
module xcore_if_ras #(
  parameter int LEN   = 32,
  parameter int DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_push,
  input  logic           i_pop,
  input  logic [LEN-1:0] i_push_data,
  output logic [LEN-1:0] o_top,
  output logic           o_empty,
  output logic           o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [LEN-1:0] mem_q [DEPTH];
  logic [PW-1:0]  tp_q, tp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wr_en;
  logic [PW-1:0]  wr_idx;

  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = tp_q;
    if (i_push && i_pop && !o_empty) begin
      wr_en = 1'b1;
    end else if (i_push) begin
      tp_d   = tp_q + 1'b1;
      wr_idx = tp_q + 1'b1;
      wr_en  = 1'b1;
      if (!o_full) cnt_d = cnt_q + 1'b1;
    end else if (i_pop && !o_empty) begin
      tp_d  = tp_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by cnt_q alone.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && wr_en) mem_q[wr_idx] <= i_push_data;
  end

  assign o_top   = mem_q[tp_q];
  assign o_empty = (cnt_q == '0);
  assign o_full  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/xcore_if_bpu_ctrl.sv
// IF-stage next-PC sequencer with static prediction: jal taken, backward
// branches taken, returns predicted from the RAS; EX redirects override all.
module xcore_if_bpu_ctrl
  import xcore_if_bpu_ctrl_pkg::*;
#(
  parameter int             LEN       = 32,
  parameter logic [LEN-1:0] RESET_PC  = LEN'(RESET_PC_DEF),
  parameter int             RAS_DEPTH = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_if_stall,
  input  logic           i_ex_redirect,
  input  logic [LEN-1:0] i_ex_redirect_pc,
  input  logic [LEN-1:0] i_pref_instr,
  output logic [LEN-1:0] o_pc,
  output logic           o_pc_instr_vld,
  output logic [LEN-1:0] o_dec_pc,
  output logic           o_bpu_taken,
  output logic [LEN-1:0] o_bpu_target,
  output logic           o_ras_empty
);

  logic [LEN-1:0] pc_q, pc_d;
  logic [LEN-1:0] dec_pc_q, dec_pc_d;
  if_state_e      state_q, state_d;

  logic           is_jal, is_jalr, is_b, is_ret;
  logic [4:0]     rd, rs1;
  logic [LEN-1:0] jal_ofs, b_ofs;
  logic           instr_vld, bpu_taken, upd;
  logic [LEN-1:0] bpu_target;
  logic           ras_push, ras_pop, ras_empty, unused_ras_full;
  logic [LEN-1:0] ras_top;

  Xcore_if_mdec #(.LEN(LEN)) u_mdec (
    .i_instr   (i_pref_instr),
    .o_is_jal  (is_jal),
    .o_is_jalr (is_jalr),
    .o_is_b    (is_b),
    .o_rd      (rd),
    .o_rs1     (rs1),
    .o_jal_ofs (jal_ofs),
    .o_b_ofs   (b_ofs)
  );

  xcore_if_ras #(.LEN(LEN), .DEPTH(RAS_DEPTH)) u_ras (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (ras_push),
    .i_pop       (ras_pop),
    .i_push_data (dec_pc_q + LEN'(4)),
    .o_top       (ras_top),
    .o_empty     (ras_empty),
    .o_full      (unused_ras_full)
  );

  always_comb begin
    instr_vld = (state_q == RUN) && !i_if_stall;
    is_ret    = is_jalr && is_link(rs1) && (rs1 != rd);
    bpu_taken = instr_vld && (is_jal || (is_b && b_ofs[LEN-1]) || (is_ret && !ras_empty));
    if (is_jal)    bpu_target = dec_pc_q + jal_ofs;
    else if (is_b) bpu_target = dec_pc_q + b_ofs;
    else           bpu_target = ras_top;
    // Wrong-path pushes/pops are tolerated; only redirect-cycle updates are blocked.
    upd      = instr_vld && !i_ex_redirect;
    ras_push = upd && (is_jal || is_jalr) && is_link(rd);
    ras_pop  = upd && is_jalr && is_link(rs1) && !(is_link(rd) && (rs1 == rd));
  end

  always_comb begin
    pc_d     = pc_q;
    dec_pc_d = dec_pc_q;
    state_d  = state_q;
    if (i_ex_redirect) begin
      pc_d    = i_ex_redirect_pc;
      state_d = SQUASH;
      if (!i_if_stall) dec_pc_d = pc_q;
    end else if (!i_if_stall) begin
      dec_pc_d = pc_q;
      if (bpu_taken) begin
        pc_d    = bpu_target;
        state_d = SQUASH;
      end else begin
        pc_d    = pc_q + LEN'(4);
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q     <= RESET_PC;
      dec_pc_q <= RESET_PC;
      state_q  <= BOOT;
    end else begin
      pc_q     <= pc_d;
      dec_pc_q <= dec_pc_d;
      state_q  <= state_d;
    end
  end

  assign o_pc           = pc_q;
  assign o_dec_pc       = dec_pc_q;
  assign o_pc_instr_vld = instr_vld;
  assign o_bpu_taken    = bpu_taken;
  assign o_bpu_target   = bpu_target;
  assign o_ras_empty    = ras_empty;

endmodule
